// File: rtl/uart_pkg.sv
// Shared types and helpers for the 8N1 UART: TX/RX state encodings and the
// bit-period divider computation.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP,
    TX_DONE
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_STOP,
    RX_DONE
  } rx_state_e;

  // Clock cycles per serial bit, truncated.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_if.sv
// UART pin bundle. master = host side driving the line and byte inputs;
// slave = whole device; tx_side / rx_side = per-direction engine views.
interface uart_if;
  logic       rx;
  logic [7:0] dintx;
  logic       send;
  logic       tx;
  logic [7:0] doutrx;
  logic       donetx;
  logic       donerx;

  modport master  (output rx, dintx, send, input tx, doutrx, donetx, donerx);
  modport slave   (input rx, dintx, send, output tx, doutrx, donetx, donerx);
  modport tx_side (input dintx, send, output tx, donetx);
  modport rx_side (input rx, output doutrx, donerx);
endinterface

// File: rtl/uart_rx.sv
// 8N1 receiver sampling the line once per uclk rising tick.
// Define UART_FRAMING_CHECK_EN to drop frames whose stop bit reads 0.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 1000000,
  parameter int unsigned BAUD_RATE = 9600
) (
  input logic      clk,
  input logic      rst,
  uart_if.rx_side  bus
);
  localparam int unsigned DIV  = calc_div(CLK_FREQ, BAUD_RATE);
  localparam int unsigned HALF = DIV / 2;
  localparam int unsigned CW   = $clog2(HALF + 1);

  logic [CW-1:0] div_q;
  logic          uclk;
  logic          tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      uclk  <= 1'b0;
    end else if (div_q == CW'(HALF - 1)) begin
      div_q <= '0;
      uclk  <= ~uclk;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  assign tick = (div_q == CW'(HALF - 1)) && !uclk;

  // The line is asynchronous to clk; resynchronise before use.
  logic rx_meta_q, rx_sync_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  rx_state_e  state_q, state_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] dout_q, dout_d;
  logic       done_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RX_IDLE;
      bit_q   <= '0;
      shift_q <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    done_c  = 1'b0;
    case (state_q)
      RX_IDLE: if (tick && !rx_sync_q) begin
        bit_d   = '0;
        state_d = RX_DATA;
      end
      RX_DATA: if (tick) begin
        shift_d[bit_q] = rx_sync_q;
        if (bit_q == 3'd7) state_d = RX_STOP;
        else               bit_d   = bit_q + 3'd1;
      end
      RX_STOP: if (tick) begin
`ifdef UART_FRAMING_CHECK_EN
        if (rx_sync_q) begin
          dout_d  = shift_q;
          state_d = RX_DONE;
        end else begin
          state_d = RX_IDLE;
        end
`else
        dout_d  = shift_q;
        state_d = RX_DONE;
`endif
      end
      RX_DONE: begin
        done_c = 1'b1;
        if (tick) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign bus.doutrx = dout_q;
  assign bus.donerx = done_c;
endmodule

// File: rtl/uart_tx.sv
// 8N1 transmitter. A free-running divider makes uclk; the FSM advances only
// on the clk cycle where uclk rises (tick).
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 1000000,
  parameter int unsigned BAUD_RATE = 9600
) (
  input logic      clk,
  input logic      rst,
  uart_if.tx_side  bus
);
  localparam int unsigned DIV  = calc_div(CLK_FREQ, BAUD_RATE);
  localparam int unsigned HALF = DIV / 2;
  localparam int unsigned CW   = $clog2(HALF + 1);

  logic [CW-1:0] div_q;
  logic          uclk;
  logic          tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      uclk  <= 1'b0;
    end else if (div_q == CW'(HALF - 1)) begin
      div_q <= '0;
      uclk  <= ~uclk;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  assign tick = (div_q == CW'(HALF - 1)) && !uclk;

  tx_state_e  state_q, state_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] data_q, data_d;
  logic       tx_c, done_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TX_IDLE;
      bit_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    data_d  = data_q;
    tx_c    = 1'b1;
    done_c  = 1'b0;
    case (state_q)
      TX_IDLE: if (tick && bus.send) begin
        data_d  = bus.dintx;
        state_d = TX_START;
      end
      TX_START: begin
        tx_c = 1'b0;
        if (tick) begin
          bit_d   = '0;
          state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        tx_c = data_q[bit_q];
        if (tick) begin
          if (bit_q == 3'd7) state_d = TX_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      TX_STOP: if (tick) state_d = TX_DONE;
      TX_DONE: begin
        done_c = 1'b1;
        if (tick) state_d = TX_IDLE;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  assign bus.tx     = tx_c;
  assign bus.donetx = done_c;
endmodule

// File: rtl/uart.sv
// UART top: independent 8N1 transmitter and receiver sharing only clk/rst.
// Optional UART_FRAMING_CHECK_EN enables stop-bit validation in the receiver.
module uart #(
  parameter int unsigned CLK_FREQ  = 1000000,
  parameter int unsigned BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic [7:0] dintx,
  input  logic       send,
  output logic       tx,
  output logic [7:0] doutrx,
  output logic       donetx,
  output logic       donerx
);
  uart_if bus ();

  assign bus.rx    = rx;
  assign bus.dintx = dintx;
  assign bus.send  = send;
  assign tx        = bus.tx;
  assign doutrx    = bus.doutrx;
  assign donetx    = bus.donetx;
  assign donerx    = bus.donerx;

  uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) utx (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) urx (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
endmodule

// File: tb/tb_uart.sv
// Scoreboard bench for uart: expected bytes are queued as frames are driven
// and popped when the DUT reports a completed frame.
module tb_uart;
  localparam int BIT = 104;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_if ubus ();

  uart #(.CLK_FREQ(1000000), .BAUD_RATE(9600)) dut (
    .clk    (clk),
    .rst    (rst),
    .rx     (ubus.rx),
    .dintx  (ubus.dintx),
    .send   (ubus.send),
    .tx     (ubus.tx),
    .doutrx (ubus.doutrx),
    .donetx (ubus.donetx),
    .donerx (ubus.donerx)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  int n_txp = 0, n_rxp = 0, exp_txp = 0, exp_rxp = 0;
  bit mon_tx_en = 1'b0;
  logic [7:0] last_rx = 8'h00;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Pulse counting, RX scoreboard and donerx width.
  initial begin : rxmon
    logic dtx_p, drx_p;
    int   drx_w;
    dtx_p = 1'b0; drx_p = 1'b0; drx_w = 0;
    forever begin
      @(negedge clk);
      if (!rst && ubus.donetx === 1'b1 && !dtx_p) n_txp++;
      if (!rst && ubus.donerx === 1'b1 && !drx_p) begin
        n_rxp++;
        if (rxq.size() == 0) chk("rx_unexpected", 1, 0);
        else                 chk("doutrx", ubus.doutrx, rxq.pop_front());
      end
      if (ubus.donerx === 1'b1) drx_w++;
      else begin
        if (drx_p) chk("donerx_width", drx_w, BIT);
        drx_w = 0;
      end
      dtx_p = (ubus.donetx === 1'b1);
      drx_p = (ubus.donerx === 1'b1);
    end
  end

  // TX line decoder: samples mid-bit after a falling start edge.
  initial begin : txmon
    logic [7:0] b;
    int w;
    forever begin
      @(negedge clk);
      if (mon_tx_en && !rst && ubus.tx === 1'b0) begin
        repeat (BIT/2) @(negedge clk);
        chk("tx_start", ubus.tx, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          b[i] = ubus.tx;
        end
        repeat (BIT) @(negedge clk);
        chk("tx_stop", ubus.tx, 1);
        w = 0;
        repeat (BIT + BIT/2) begin
          @(negedge clk);
          if (ubus.donetx === 1'b1) w++;
        end
        chk("donetx_width", w, BIT);
        if (txq.size() == 0) chk("tx_unexpected", 1, 0);
        else                 chk("tx_byte", b, txq.pop_front());
      end
    end
  end

  task automatic wait_sig(input string tag, input int which, input logic val, input int lim);
    int t = 0;
    logic s;
    forever begin
      case (which)
        0:       s = ubus.tx;
        default: s = ubus.donetx;
      endcase
      if (s === val || t >= lim) break;
      @(negedge clk);
      t++;
    end
    if (t >= lim) chk({tag, "_timeout"}, 1, 0);
  endtask

  task automatic send_tx(input logic [7:0] d);
    txq.push_back(d);
    exp_txp++;
    ubus.dintx = d;
    ubus.send  = 1'b1;
    wait_sig("tx_fall", 0, 1'b0, 2000);
    ubus.dintx = ~d;
    wait_sig("donetx_rise", 1, 1'b1, 2000);
    ubus.send = 1'b0;
    wait_sig("donetx_fall", 1, 1'b0, 500);
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop, input bit ok);
    if (ok) begin
      rxq.push_back(d);
      exp_rxp++;
      last_rx = d;
    end
    ubus.rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ubus.rx = d[i];
      repeat (BIT) @(negedge clk);
    end
    ubus.rx = stop;
    repeat (BIT) @(negedge clk);
    ubus.rx = 1'b1;
    repeat (3*BIT) @(negedge clk);
  endtask

  initial begin : main
    int t0[2], t1[2], c, quiet;
    logic p[2], u[2];
    logic [7:0] rb, tb_b;

    ubus.rx = 1'b1; ubus.send = 1'b0; ubus.dintx = 8'h00;

    // Reset values, held for 5 clocks
    repeat (2) @(negedge clk);
    chk("rst_tx", ubus.tx, 1);
    chk("rst_donetx", ubus.donetx, 0);
    chk("rst_donerx", ubus.donerx, 0);
    chk("rst_doutrx", ubus.doutrx, 8'h00);
    chk("rst_uclk", {dut.utx.uclk, dut.urx.uclk}, 2'b00);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_tx", ubus.tx, 1);
    chk("post_rst_doutrx", ubus.doutrx, 8'h00);

    // uclk period in both directions
    t0 = '{-1, -1}; t1 = '{-1, -1}; p = '{1'b0, 1'b0}; c = 0;
    while ((t1[0] < 0 || t1[1] < 0) && c < 400) begin
      @(negedge clk);
      c++;
      u[0] = dut.utx.uclk;
      u[1] = dut.urx.uclk;
      for (int k = 0; k < 2; k++) begin
        if (u[k] && !p[k]) begin
          if (t0[k] < 0) t0[k] = c;
          else if (t1[k] < 0) t1[k] = c;
        end
        p[k] = u[k];
      end
    end
    chk("uclk_period_tx", t1[0] - t0[0], BIT);
    chk("uclk_period_rx", t1[1] - t0[1], BIT);

    mon_tx_en = 1'b1;
    send_tx(8'hA5);
    send_rx(8'h3C, 1'b1, 1'b1);

    // Random bytes, TX and RX concurrently
    for (int n = 0; n < 5; n++) begin
      tb_b = 8'($urandom_range(0, 255));
      rb   = 8'($urandom_range(0, 255));
      fork
        send_tx(tb_b);
        send_rx(rb, 1'b1, 1'b1);
      join
    end

    // Send held high across DONE: second frame starts right away
    txq.push_back(8'h11); exp_txp++;
    ubus.dintx = 8'h11; ubus.send = 1'b1;
    wait_sig("b2b_fall1", 0, 1'b0, 2000);
    ubus.dintx = 8'h22;
    txq.push_back(8'h22); exp_txp++;
    wait_sig("b2b_done1", 1, 1'b1, 2000);
    wait_sig("b2b_done1f", 1, 1'b0, 500);
    wait_sig("b2b_fall2", 0, 1'b0, 2*BIT);
    ubus.dintx = 8'h33;
    wait_sig("b2b_done2", 1, 1'b1, 2000);
    ubus.send = 1'b0;
    wait_sig("b2b_done2f", 1, 1'b0, 500);
    repeat (2*BIT) @(negedge clk);

    // Stop bit 0
`ifdef UART_FRAMING_CHECK_EN
    rb = last_rx;
    send_rx(8'h55, 1'b0, 1'b0);
    chk("framing_doutrx_hold", ubus.doutrx, rb);
`else
    send_rx(8'h55, 1'b0, 1'b1);
    chk("nocheck_doutrx", ubus.doutrx, 8'h55);
`endif

    // Reset in the middle of TX bit 4 (E9 has bit4 = 0)
    mon_tx_en = 1'b0;
    ubus.dintx = 8'hE9; ubus.send = 1'b1;
    wait_sig("abort_fall", 0, 1'b0, 2000);
    ubus.send = 1'b0;
    repeat (BIT/2 + 5*BIT) @(negedge clk);
    chk("abort_bit4", ubus.tx, 0);
    rst = 1'b1;
    #1;
    chk("abort_tx", ubus.tx, 1);
    chk("abort_donetx", ubus.donetx, 0);
    chk("abort_doutrx", ubus.doutrx, 8'h00);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    quiet = 0;
    repeat (15*BIT) begin
      @(negedge clk);
      if (ubus.tx !== 1'b1 || ubus.donetx !== 1'b0) quiet++;
    end
    chk("abort_quiet", quiet, 0);

    c = 0;
    while ((txq.size() != 0 || rxq.size() != 0) && c < 3000) begin
      @(negedge clk);
      c++;
    end
    chk("txq_drained", txq.size(), 0);
    chk("rxq_drained", rxq.size(), 0);
    chk("donetx_count", n_txp, exp_txp);
    chk("donerx_count", n_rxp, exp_rxp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/uart.md
UART -- requirements
Module: uart

Interface
- REQ-001: Parameter CLK_FREQ, default 1000000, system clock frequency in Hz; first positional parameter.
- REQ-002: Parameter BAUD_RATE, default 9600, serial bit rate; second positional parameter.
- REQ-003: clk  input  1  the single clock.
- REQ-004: rst  input  1  asynchronous, active-high reset.
- REQ-005: rx  input  1  serial receive line; idles high.
- REQ-006: dintx  input  8  byte to transmit.
- REQ-007: send  input  1  transmit request; level-sampled.
- REQ-008: tx  output  1  serial transmit line; idles high.
- REQ-009: doutrx  output  8  last received byte.
- REQ-010: donetx  output  1  transmit-complete pulse.
- REQ-011: donerx  output  1  receive-complete pulse.

Function
- REQ-012: Frame SHALL be 8N1: start bit 0, 8 data bits LSB first, stop bit 1.
- REQ-013: DIV SHALL equal CLK_FREQ/BAUD_RATE with integer truncation; DIV is 104 at the defaults.
- REQ-014: Each direction SHALL generate an internal signal uclk with period DIV clk cycles.
- REQ-015: uclk SHALL toggle every DIV/2 clk cycles; DIV/2 is 52 at the defaults.
- REQ-016: All logic SHALL be clocked by clk; state advances only on the cycle where uclk rises (the bit tick).
- REQ-017: TX states SHALL be IDLE, START, DATA, STOP, DONE.
- REQ-018: In IDLE with send=1 at a tick, TX SHALL capture dintx and enter START, driving tx=0 for one bit.
- REQ-019: In DATA, TX SHALL drive bits 0..7 of the captured byte, one per tick.
- REQ-020: STOP SHALL drive tx=1 for one bit, then TX enters DONE.
- REQ-021: In DONE, donetx SHALL be high for exactly one bit time, then TX returns to IDLE.
- REQ-022: send SHALL be ignored outside IDLE; dintx changes after capture SHALL NOT affect the frame.
- REQ-023: If send is still high when TX returns to IDLE, a new frame SHALL start at the next tick.
- REQ-024: RX states SHALL be IDLE, DATA, STOP, DONE.
- REQ-025: In IDLE, rx=0 at a tick SHALL be taken as the start bit.
- REQ-026: In DATA, RX SHALL sample the next 8 ticks into bits 0..7.
- REQ-027: At the stop tick, doutrx SHALL update and donerx SHALL be high for exactly one bit time.
- REQ-028: doutrx SHALL hold its value until the next completed frame.
- REQ-029: TX and RX SHALL operate independently and concurrently.

Reset
- REQ-030: While rst=1, tx=1, donetx=0, donerx=0, doutrx=8'h00.
- REQ-031: While rst=1, both FSMs SHALL be in IDLE, and the uclk dividers and bit counters SHALL be 0.
- REQ-032: Reset asserted mid-frame SHALL abort the frame immediately without a done pulse.

Configuration
- REQ-033: With UART_FRAMING_CHECK_EN defined, RX SHALL require stop bit=1.
- REQ-034: Under UART_FRAMING_CHECK_EN, a frame with stop bit 0 SHALL leave doutrx unchanged, produce no donerx, and return RX to IDLE.
- REQ-035: Without UART_FRAMING_CHECK_EN, the stop bit SHALL NOT be checked.

Structure
- REQ-036: Package uart_pkg SHALL hold the TX and RX state enums and a DIV-computation function.
- REQ-037: Sub-modules uart_tx and uart_rx SHALL be instantiated as utx and urx.
- REQ-038: utx and urx SHALL each contain a signal named uclk, visible hierarchically as dut.utx.uclk and dut.urx.uclk.

Verification
- REQ-039: rst high for 5 clk, then low -> tx=1, donetx=0, donerx=0, doutrx=0; uclk period 104 clk.
- REQ-040: dintx=8'hA5, send=1 -> tx sequence 0,1,0,1,0,0,1,0,1,1 at one bit per 104 clk, then one donetx pulse.
- REQ-041: rx driven with 8'h3C as an 8N1 frame at 104 clk/bit -> doutrx=8'h3C and one donerx pulse.
- REQ-042: 5 random bytes, each sent on tx and also fed on rx -> every donetx frame matches dintx and every doutrx matches the rx stimulus.
- REQ-043: rst asserted during TX bit 4 -> tx=1 immediately and no donetx pulse.
- REQ-044: With UART_FRAMING_CHECK_EN, rx frame 8'h55 with stop bit 0 -> no donerx and doutrx unchanged.
